param_tx_fifo: RTL
==================

Name: param_tx_fifo

Overview:
- Parametrised, first-word-fall-through (FWFT) transmit FIFO.
- Successor to the fixed 8-bit, 8-deep tx FIFO. Sits between the AES datapath byte producer and the SD-card transmit serializer.
- Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8, bits per entry (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 1, almost_empty asserts when count <= AEMPTY_LEVEL.
- CW, $clog2(DEPTH+1), count width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO on the next edge.
- write_enable  in  1  push request.
- write_data  in  DATA_WIDTH  push data.
- read_enable  in  1  pop request.
- read_data  out  DATA_WIDTH  head entry (FWFT); 0 when empty.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async, rst=1):
  - wptr=0, rptr=0, count=0, overflow=0, underflow=0.
  - Outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AFULL_LEVEL==0), read_data=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Storage: DEPTH x DATA_WIDTH register array. wptr and rptr range 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, not binary rollover). count is an explicit counter.
- Write accepted when write_enable=1 and (count<DEPTH, or read accepted in the same cycle). Accepted write stores write_data at wptr on the edge; wptr advances.
- Read accepted when read_enable=1 and count>0. Accepted read advances rptr on the edge.
- read_data = mem[rptr], combinational from registered state. A write into an empty FIFO is visible on read_data the cycle after the write edge (1-cycle write-to-read latency). No read is required to see the head.
- count update:
  - +1 on a write alone.
  - -1 on a read alone.
  - Unchanged on a simultaneous accepted read and write.
- Simultaneous read+write when full: both accepted; count stays DEPTH; the written word lands in the slot vacated by the pop.
- Simultaneous read+write when empty: write accepted, read rejected (underflow set); count becomes 1.
- Rejected write (full, no read): data dropped, pointers unchanged, overflow <= 1.
- Rejected read (empty): pointers unchanged, underflow <= 1.
- overflow and underflow stay set until rst or clear.
- clear=1 (synchronous):
  - Next edge: wptr=rptr=0, count=0, overflow=underflow=0.
  - clear has priority over any write or read in the same cycle; those are ignored and raise no error flag.
- All status flags are decoded from registered count. They change in the cycle after the causing edge, never combinationally from the enables.

Test Plan:
- Reset then write 0xFF once, no read -> next cycle read_data=0xFF, count=1, fifo_empty=0, almost_empty=1.
- Write 0x01..0x08 on consecutive cycles -> fifo_full=1, count=8, almost_full=1 from count=6. Ninth write of 0x09 -> overflow=1, contents unchanged. Eight reads return 0x01..0x08 in order, then fifo_empty=1.
- Fill to 8, then hold read_enable=write_enable=1 for 10 cycles with data 0xA0+i -> count stays 8, no overflow, output order continuous across the pointer wrap.
- Empty FIFO, read_enable=write_enable=1 with 0x5A -> underflow=1, count=1, read_data=0x5A next cycle.
- Load 5 entries, assert clear together with write_enable -> count=0, fifo_empty=1, overflow=underflow=0, read_data=0.
- Load 3 entries, pulse rst between clock edges -> outputs reach reset values immediately, without waiting for a clock edge. A subsequent write of 0x3C reads back as 0x3C.
- Repeat the full-flag, wrap and order scenarios with DATA_WIDTH=16, DEPTH=5 -> wrap at index 4, fifo_full at count=5.

Source files
------------

// File: rtl/param_tx_fifo.sv
// First-word-fall-through transmit FIFO with configurable width/depth, occupancy
// count, programmable almost-full/almost-empty flags, synchronous flush and sticky error flags.
module param_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 1,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  // One extra bit so the level thresholds compare without truncation.
  localparam logic [CW:0]   AFULL_C   = (CW + 1)'(AFULL_LEVEL);
  localparam logic [CW:0]   AEMPTY_C  = (CW + 1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_acc = read_enable && !clear && (count_q != '0);
  assign wr_acc = write_enable && !clear && ((count_q != DEPTH_C) || rd_acc);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + AW'(1);
      end
      if (rd_acc) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (write_enable && !wr_acc) begin
        overflow_d = 1'b1;
      end
      if (read_enable && !rd_acc) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage holds no reset; an empty FIFO masks whatever stale data it contains.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= write_data;
    end
  end

  assign read_data    = (count_q == '0) ? '0 : mem_q[rptr_q];
  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH_C);
  assign almost_full  = ({1'b0, count_q} >= AFULL_C);
  assign almost_empty = ({1'b0, count_q} <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
